// File: rtl/afifo_pkg.sv
// Shared types and sizing helpers for the async FIFO read/write schedulers.
package afifo_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2
  } afifo_arb_state_e;

  // Empty-stall limit used when the burst timeout is compiled in.
  localparam int unsigned AFIFO_TIMEOUT_CYCLES = 64;

  // Index width for n items; never returns 0 so single-item configs stay legal.
  function automatic int unsigned afifo_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afifo_rr_picker.sv
// Rotating-priority picker: selects the first asserted request at or above
// ptr_i (wrapping) and returns it one-hot plus its index. Purely combinational.
module afifo_rr_picker
  import afifo_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = afifo_idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Walk the requests starting at the pointer and keep the first hit.
  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] jj;
    // NOTE: every output gets a default before any branch, so no path leaves a value unassigned and no latch is inferred.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(ptr_i) + k) % N;
      jj = IDX_W'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o   = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/afifo_rd_arbiter.sv
// Read-side scheduler for the async FIFO: round-robin burst grants over one
// FIFO read port, pops sequenced against rempty, and a registered output word
// tagged with requester id and last-beat flag under valid/ready.
// Optional macro AFIFO_RD_ARB_TIMEOUT_EN adds an empty-stall burst abort.
module afifo_rd_arbiter
  import afifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_BURST      = 8,
  parameter int unsigned TIMEOUT_CYCLES = AFIFO_TIMEOUT_CYCLES,
  localparam int unsigned ID_W          = afifo_idx_w(NUM_REQ),
  localparam int unsigned LEN_W         = afifo_idx_w(MAX_BURST)
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [ID_W-1:0]          rd_id,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     rinc,
  input  logic                     rempty,
  input  logic [DATA_WIDTH-1:0]    rdata
);

  // Reject illegal configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 2 ||
      (MAX_BURST & (MAX_BURST - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("afifo_rd_arbiter: illegal parameter set");
  end

  afifo_arb_state_e        state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         rd_id_q, rd_id_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_valid;
  logic [LEN_W-1:0]        pick_len;
  logic                    pop;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = afifo_idx_w(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0]      stall_q, stall_d;
  logic                    timeout_err_q, timeout_err_d;
`endif

  afifo_rr_picker #(.N(NUM_REQ), .IDX_W(ID_W)) u_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Extract the burst length of the picked requester.
  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) pick_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Pop only in XFER with data available and room in the output register;
  // held low while reset is asserted.
  assign pop = rrst_n && (state_q == ARB_XFER) && !rempty && (!rd_valid_q || rd_ready);

  // Next-state and datapath update for the IDLE/XFER/DRAIN sequence.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    rd_id_d    = rd_id_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          rd_id_d  = pick_idx;
          cnt_d    = pick_len;
          rr_ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          state_d  = ARB_XFER;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
          stall_d  = '0;
`endif
        end
      end
      ARB_XFER: begin
        if (pop) begin
          rd_data_d  = rdata;
          rd_valid_d = 1'b1;
          rd_last_d  = (cnt_q == '0);
          if (cnt_q == '0) state_d = ARB_DRAIN;
          else             cnt_d   = cnt_q - LEN_W'(1);
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end else begin
          if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
          // Abort a burst that has waited on an empty FIFO for too long; a
          // word still waiting in the output register closes the burst.
          if (rempty) begin
            if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
              timeout_err_d = 1'b1;
              gnt_d         = '0;
              stall_d       = '0;
              if (rd_valid_q && !rd_ready) begin
                rd_last_d = 1'b1;
                state_d   = ARB_DRAIN;
              end else begin
                state_d   = ARB_IDLE;
              end
            end else begin
              stall_d = stall_q + STALL_W'(1);
            end
          end
`endif
        end
      end
      ARB_DRAIN: begin
        if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          gnt_d      = '0;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      // NOTE: rd_data is a plain datapath register but its reset value is visible on the port, so it is reset with the control state.
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      rd_id_q    <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge values, independent of statement order.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_id_q    <= rd_id_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign rinc     = pop;
  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;
  assign busy     = (state_q != ARB_IDLE);
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // The FIFO must never be popped while it reports empty.
  a_no_pop_when_empty: assert property (@(posedge rclk) disable iff (!rrst_n) !(rinc && rempty));

endmodule

// File: tb/tb_afifo_rd_arbiter.sv
// Self-checking bench for afifo_rd_arbiter: a queue-based FIFO model feeds the
// read port and a scoreboard of expected {data, id, last} beats is filled as
// words are loaded and drained as the DUT hands words to the consumer.
// Define AFIFO_RD_ARB_TIMEOUT_EN for both bench and RTL to run the timeout test.
module tb_afifo_rd_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int TO = 64;
  localparam int IW = 2;
  localparam int LW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [NR-1:0]    req;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    gnt;
  logic             rd_valid, rd_ready, rd_last, busy, timeout_err, rinc, rempty;
  logic [DW-1:0]    rd_data, rdata;
  logic [IW-1:0]    rd_id;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, pops = 0, accs = 0, busy_cyc = 0, first_pop = -1, last_pop = -1;
  logic s_rinc, s_te, s_last, hold_on;
  logic [NR-1:0] s_gnt;
  beat_t held;
  bit chk_gnt = 1'b1;

  afifo_rd_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .rclk(rclk), .rrst_n(rrst_n), .req(req), .req_len(req_len), .gnt(gnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_id(rd_id),
    .rd_last(rd_last), .busy(busy), .timeout_err(timeout_err), .rinc(rinc),
    .rempty(rempty), .rdata(rdata)
  );

  always #5 rclk = ~rclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic refresh();
    rempty = (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // Put n words in the FIFO and the matching expected beats in the scoreboard.
  task automatic load(input int id, input int n, input logic [DW-1:0] base, input bit last_at_end);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      fifo.push_back(base + DW'(k));
      b.data = base + DW'(k);
      b.id   = IW'(id);
      b.last = last_at_end && (k == n - 1);
      exp_q.push_back(b);
    end
    refresh();
  endtask

  // One clock: observe at the falling edge, then advance the FIFO model just after the rising edge.
  task automatic cycle();
    beat_t e;
    logic [NR-1:0] oh;
    logic [DW-1:0] dummy;
    @(negedge rclk);
    cyc++;
    s_rinc = rinc; s_te = timeout_err; s_gnt = gnt; s_last = rd_last;
    if (busy === 1'b1) busy_cyc++;
    vectors++;
    if (rinc === 1'b1 && rempty === 1'b1) begin
      miscompares++;
      $display("FAIL pop_while_empty: rinc=%b rempty=%b", rinc, rempty);
    end
`ifndef AFIFO_RD_ARB_TIMEOUT_EN
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_tied_low: got %b want 0", timeout_err);
    end
`endif
    if (hold_on && timeout_err !== 1'b1) begin
      vectors++;
      if ({rd_valid, rd_data, rd_id, rd_last} !== {1'b1, held.data, held.id, held.last}) begin
        miscompares++;
        $display("FAIL stall_stable: got v=%b d=%h id=%0d l=%b want v=1 d=%h id=%0d l=%b",
                 rd_valid, rd_data, rd_id, rd_last, held.data, held.id, held.last);
      end
    end
    hold_on = (rd_valid === 1'b1) && (rd_ready === 1'b0) && rrst_n;
    held    = {rd_data, rd_id, rd_last};
    if (rd_valid === 1'b1 && rd_ready && rrst_n) begin
      accs++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got d=%h id=%0d, want no beat", rd_data, rd_id);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e.data || rd_id !== e.id || rd_last !== e.last) begin
          miscompares++;
          $display("FAIL beat: got d=%h id=%0d l=%b want d=%h id=%0d l=%b",
                   rd_data, rd_id, rd_last, e.data, e.id, e.last);
        end
        if (chk_gnt) begin
          oh = '0; oh[e.id] = 1'b1;
          vectors++;
          if (gnt !== oh) begin
            miscompares++;
            $display("FAIL gnt_during_beat: got %b want %b", gnt, oh);
          end
        end
      end
    end
    if (s_rinc === 1'b1) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    @(posedge rclk);
    #1;
    if (s_rinc === 1'b1 && fifo.size() != 0) dummy = fifo.pop_front();
    refresh();
  endtask

  // Run until the scoreboard is empty and the arbiter is idle; drop req once all data is out.
  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      cycle();
      n++;
      if (exp_q.size() == 0) req = '0;
    end
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_budget: got %0d beats left busy=%b, want 0 and busy=0", exp_q.size(), busy);
    end
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; req = '0; rd_ready = 1'b1; hold_on = 1'b0;
    cycle(); cycle();
    rrst_n = 1'b1;
    exp_q.delete(); fifo.delete(); refresh(); hold_on = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({gnt, rd_valid, rd_last, rd_id, busy, timeout_err, rinc} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got gnt=%b v=%b l=%b id=%0d busy=%b te=%b rinc=%b want all 0",
               gnt, rd_valid, rd_last, rd_id, busy, timeout_err, rinc);
    end
    vectors++;
    if (rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", rd_data);
    end
    cycle();
    vectors++;
    if (busy !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL idle_no_req: got busy=%b gnt=%b want 0/0", busy, gnt);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    req_len = '0; req_len[0 +: LW] = 3'd3;
    load(0, 4, 32'hA0, 1'b1);
    pops = 0; busy_cyc = 0; first_pop = -1; last_pop = -1;
    req = 4'b0001;
    cycle();
    req = '0;
    vectors++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got gnt=%b busy=%b want 0001/1", gnt, busy);
    end
    drain(30);
    vectors++;
    if (pops != 4 || last_pop - first_pop != 3) begin
      miscompares++;
      $display("FAIL single_pops: got %0d pops over %0d cycles want 4 over 3", pops, last_pop - first_pop);
    end
    // 4 XFER cycles + 1 DRAIN cycle; with the IDLE grant cycle that is L+3.
    vectors++;
    if (busy_cyc != 5 || gnt !== '0) begin
      miscompares++;
      $display("FAIL single_occupancy: got busy=%0d gnt=%b want 5 and 0000", busy_cyc, gnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_len = '0;
    for (int k = 0; k < 8; k++) load(k % NR, 1, 32'hB0 + DW'(k), 1'b1);
    accs = 0;
    req = 4'b1111;
    drain(80);
    vectors++;
    if (accs != 8) begin
      miscompares++;
      $display("FAIL rr_count: got %0d beats want 8", accs);
    end
  endtask

  task automatic test_back_to_back();
    req_len = '0; req_len[2*LW +: LW] = 3'd1;
    load(2, 2, 32'hC0, 1'b1);
    load(2, 2, 32'hC2, 1'b1);
    pops = 0;
    req = 4'b0100;
    drain(40);
    vectors++;
    if (pops != 4) begin
      miscompares++;
      $display("FAIL b2b_pops: got %0d want 4", pops);
    end
  endtask

  task automatic test_empty_stall();
    int n = 0;
    req_len = '0; req_len[1*LW +: LW] = 3'd7;
    load(1, 2, 32'hD0, 1'b0);
    pops = 0;
    req = 4'b0010;
    cycle();
    req = '0;
    while (fifo.size() != 0 && n < 10) begin cycle(); n++; end
    for (int k = 0; k < 5; k++) begin
      cycle();
      vectors++;
      if (s_rinc !== 1'b0 || s_gnt !== 4'b0010) begin
        miscompares++;
        $display("FAIL stall_hold: got rinc=%b gnt=%b want 0/0010", s_rinc, s_gnt);
      end
    end
    load(1, 6, 32'hD2, 1'b1);
    drain(40);
    vectors++;
    if (pops != 8) begin
      miscompares++;
      $display("FAIL stall_pops: got %0d want 8", pops);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int a0;
    req_len = '0; req_len[0 +: LW] = 3'd3;
    load(0, 4, 32'hE0, 1'b1);
    req = 4'b0001;
    cycle();
    req = '0;
    a0 = accs;
    while (accs - a0 < 2 && n < 20) begin cycle(); n++; end
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      vectors++;
      if (s_rinc !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_no_pop: got rinc=%b want 0", s_rinc);
      end
    end
    rd_ready = 1'b1;
    drain(30);
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    req_len = '0; req_len[0 +: LW] = 3'd3;
    load(0, 4, 32'hF0, 1'b1);
    pops = 0;
    req = 4'b0001;
    cycle();
    while (pops < 2 && n < 20) begin cycle(); n++; end
    rrst_n = 1'b0;
    cycle();
    vectors++;
    if (s_rinc !== 1'b0) begin
      miscompares++;
      $display("FAIL rinc_in_reset: got %b want 0", s_rinc);
    end
    rrst_n = 1'b1;
    vectors++;
    if ({gnt, rd_valid, rd_last, rd_id, busy, timeout_err} !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL midburst_reset: got gnt=%b v=%b l=%b id=%0d busy=%b d=%h want all 0",
               gnt, rd_valid, rd_last, rd_id, busy, rd_data);
    end
    exp_q.delete(); fifo.delete(); hold_on = 1'b0;
    load(0, 4, 32'hF8, 1'b1);
    cycle();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL regrant_after_reset: got %b want 0001", gnt);
    end
    drain(30);
  endtask

`ifdef AFIFO_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bit seen = 1'b0;
    do_reset();
    req_len = '0; req_len[0 +: LW] = 3'd3;
    load(0, 1, 32'h5A, 1'b1);
    chk_gnt = 1'b0; rd_ready = 1'b0; pops = 0;
    req = 4'b0001;
    cycle();
    req = '0;
    while (pops < 1 && n < 10) begin cycle(); n++; end
    n = 0;
    while (!seen && n < 4 * TO) begin
      cycle();
      if (s_te === 1'b1) seen = 1'b1;
      else n++;
    end
    vectors++;
    if (!seen || n != TO) begin
      miscompares++;
      $display("FAIL timeout_delay: got seen=%b after %0d stall cycles want %0d", seen, n, TO);
    end
    vectors++;
    if (s_gnt !== '0 || s_last !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_abort: got gnt=%b last=%b want 0000/1", s_gnt, s_last);
    end
    cycle();
    vectors++;
    if (s_te !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got %b want 0", s_te);
    end
    rd_ready = 1'b1;
    drain(20);
    chk_gnt = 1'b1;
  endtask
`endif

  initial begin
    rrst_n = 1'b0; req = '0; req_len = '0; rd_ready = 1'b1; hold_on = 1'b0;
    refresh();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_back_to_back();
    test_empty_stall();
    test_backpressure();
    test_reset_mid_burst();
`ifdef AFIFO_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
